// File: rtl/fifo_pop_arbiter.sv
// fifo_pop_arbiter: drains up to four source FIFOs into one downstream FIFO.
// Issues one-hot registered read strobes, captures the source read data one
// cycle later and re-issues each word as a downstream push two cycles after
// its read strobe. Reads stop while the downstream FIFO signals pause; words
// already in flight still complete.
//
// Optional build macro: ROUND_ROBIN_EN
//   defined   -> round-robin arbitration, search starts after the last grant
//   undefined -> fixed priority, FIFO 0 highest
//
// Ports:
//   clk         clock, rising edge
//   reset       synchronous active-high reset
//   fifo_empty  per-source empty flags (bit i = FIFO i)
//   fifo_data   flattened source read data, FIFO i at [i*DATA_SIZE +: DATA_SIZE]
//   down_pause  downstream almost-full flag
//   fifo_read   one-hot read strobe to the sources
//   push        write strobe to the downstream FIFO
//   data_out    word pushed downstream
//   src_id      source index of data_out
//   idle        nothing in flight and all sources empty
module fifo_pop_arbiter #(
  parameter int unsigned DATA_SIZE = 6,
  parameter int unsigned NUM_FIFOS = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_FIFOS-1:0]           fifo_empty,
  input  logic [NUM_FIFOS*DATA_SIZE-1:0] fifo_data,
  input  logic                           down_pause,
  output logic [NUM_FIFOS-1:0]           fifo_read,
  output logic                           push,
  output logic [DATA_SIZE-1:0]           data_out,
  output logic [1:0]                     src_id,
  output logic                           idle
);

  localparam int unsigned IDX_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_FIFOS-1:0]   fifo_read_q, read_d;
  logic                   s1_vld_q;
  logic [IDX_W-1:0]       s1_idx_q;
  logic                   push_q;
  logic [DATA_SIZE-1:0]   data_q;
  logic [IDX_W-1:0]       src_q;
  logic                   idle_q, idle_d;

  logic [NUM_FIFOS-1:0]   avail;
  logic                   any_avail;
  logic                   pipe_busy;
  logic                   gnt_found;
  logic [IDX_W-1:0]       gnt_idx;
  logic [IDX_W-1:0]       rd_idx;
  logic [DATA_SIZE-1:0]   sel_word;

`ifdef ROUND_ROBIN_EN
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]       cand;
`endif

  assign avail     = ~fifo_empty;
  assign any_avail = |avail;
  // A strobe still outstanding or a word waiting for its data keeps DRAIN busy.
  assign pipe_busy = (|fifo_read_q) || s1_vld_q;

  // Arbitration: pick one non-empty source.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
`ifdef ROUND_ROBIN_EN
    cand      = '0;
    for (int k = 0; k < int'(NUM_FIFOS); k++) begin
      cand = rr_ptr_q + IDX_W'(k);
      if (!gnt_found && avail[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
`else
    for (int k = 0; k < int'(NUM_FIFOS); k++) begin
      if (!gnt_found && avail[k]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDX_W'(k);
      end
    end
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; pause always wins over a source going non-empty.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!down_pause && any_avail) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (down_pause)      state_d = ST_DRAIN;
        else if (!any_avail) state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        if (!pipe_busy) begin
          if (!down_pause && any_avail) state_d = ST_RUN;
          else                          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: a read is issued for the cycle in which the FSM is in RUN.
  always_comb begin
    read_d = '0;
`ifdef ROUND_ROBIN_EN
    rr_ptr_d = rr_ptr_q;
`endif
    if (state_d == ST_RUN && !down_pause && gnt_found) begin
      read_d[gnt_idx] = 1'b1;
`ifdef ROUND_ROBIN_EN
      rr_ptr_d = gnt_idx + IDX_W'(1);
`endif
    end
    idle_d = (state_d == ST_IDLE) && !(|read_d) && !(|fifo_read_q) &&
             !s1_vld_q && (&fifo_empty);
  end

  // Index of the source currently strobed (strobe is one-hot).
  always_comb begin
    rd_idx = '0;
    for (int i = 0; i < int'(NUM_FIFOS); i++) begin
      if (fifo_read_q[i]) rd_idx = IDX_W'(i);
    end
  end

  // Slice of the source that was read last cycle.
  always_comb begin
    sel_word = '0;
    for (int i = 0; i < int'(NUM_FIFOS); i++) begin
      if (s1_idx_q == IDX_W'(i)) sel_word = fifo_data[i*DATA_SIZE +: DATA_SIZE];
    end
  end

  // Read strobe -> stage 1 (index) -> push stage with captured data.
  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_read_q <= '0;
      s1_vld_q    <= 1'b0;
      s1_idx_q    <= '0;
      push_q      <= 1'b0;
      data_q      <= '0;
      src_q       <= '0;
      idle_q      <= 1'b1;
    end else begin
      fifo_read_q <= read_d;
      s1_vld_q    <= |fifo_read_q;
      s1_idx_q    <= rd_idx;
      push_q      <= s1_vld_q;
      if (s1_vld_q) begin
        data_q <= sel_word;
        src_q  <= s1_idx_q;
      end
      idle_q      <= idle_d;
    end
  end

`ifdef ROUND_ROBIN_EN
  // Round-robin pointer: next source to search first; moves only on a grant.
  always_ff @(posedge clk) begin
    if (reset) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end
`endif

  assign fifo_read = fifo_read_q;
  assign push      = push_q;
  assign data_out  = data_q;
  assign src_id    = src_q;
  assign idle      = idle_q;

endmodule

// File: tb/tb_fifo_pop_arbiter.sv
// Directed bench for fifo_pop_arbiter with a behavioural model of four
// source FIFOs. The source model pops on the strobe cycle (empty updates
// before the next edge) and presents the popped word during the following
// cycle. Reads and pushes are logged on the falling edge and compared
// against hand-derived sequences.
module tb_fifo_pop_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  fifo_empty;
  logic [23:0] fifo_data;
  logic        down_pause;
  logic [3:0]  fifo_read;
  logic        push;
  logic [5:0]  data_out;
  logic [1:0]  src_id;
  logic        idle;

  fifo_pop_arbiter #(.DATA_SIZE(6), .NUM_FIFOS(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .down_pause (down_pause),
    .fifo_read  (fifo_read),
    .push       (push),
    .data_out   (data_out),
    .src_id     (src_id),
    .idle       (idle)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;
  int viol  = 0;

  // Source FIFO model storage.
  logic [5:0] mem [4][64];
  int         wp [4];
  int         rp [4];
  logic [5:0] pend [4];
  logic       pend_v [4];

  // Observation logs.
  int rd_cyc[$];
  int rd_idx[$];
  int pu_cyc[$];
  int pu_dat[$];
  int pu_src[$];

  for (genvar g = 0; g < 4; g++) begin : g_empty
    assign fifo_empty[g] = (wp[g] == rp[g]);
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Falling edge: present last cycle's popped word, pop on strobe, log activity.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (pend_v[i]) begin
        fifo_data[i*6 +: 6] = pend[i];
        pend_v[i] = 1'b0;
      end
    end
    if ($countones(fifo_read) > 1) viol++;
    for (int i = 0; i < 4; i++) begin
      if (fifo_read[i]) begin
        if (wp[i] == rp[i]) viol++;
        else begin
          pend[i]   = mem[i][rp[i] & 63];
          rp[i]     = rp[i] + 1;
          pend_v[i] = 1'b1;
        end
        rd_cyc.push_back(cyc);
        rd_idx.push_back(i);
      end
    end
    if (push) begin
      pu_cyc.push_back(cyc);
      pu_dat.push_back(int'(data_out));
      pu_src.push_back(int'(src_id));
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input int i, input logic [5:0] w);
    mem[i][wp[i] & 63] = w;
    wp[i] = wp[i] + 1;
  endtask

  task automatic clear_logs();
    rd_cyc.delete(); rd_idx.delete();
    pu_cyc.delete(); pu_dat.delete(); pu_src.delete();
  endtask

  function automatic int qv(input int q[$], input int k);
    return (k < q.size()) ? q[k] : -1;
  endfunction

  int lc, pc, rc;
  int exp_ord [8];
  int nth [4];
  int ew;

  initial begin
`ifdef ROUND_ROBIN_EN
    exp_ord = '{0, 1, 2, 3, 0, 1, 2, 3};
`else
    exp_ord = '{0, 0, 1, 1, 2, 2, 3, 3};
`endif
    for (int i = 0; i < 4; i++) begin
      wp[i] = 0; rp[i] = 0; pend[i] = '0; pend_v[i] = 1'b0;
    end
    fifo_data  = '0;
    reset      = 1'b1;
    down_pause = 1'b0;

    // Reset with everything empty.
    tick(2);
    chk("rst_read", int'(fifo_read), 0);
    chk("rst_push", int'(push), 0);
    chk("rst_idle", int'(idle), 1);
    chk("rst_data", int'(data_out), 0);
    chk("rst_src",  int'(src_id), 0);
    reset = 1'b0;
    tick(2);

    // Single word from FIFO2.
    clear_logs();
    lc = cyc;
    load(2, 6'h15);
    tick(8);
    chk("sw_nreads", rd_idx.size(), 1);
    chk("sw_rd_idx", qv(rd_idx, 0), 2);
    chk("sw_rd_lat", qv(rd_cyc, 0) - lc, 1);
    chk("sw_npush",  pu_dat.size(), 1);
    chk("sw_data",   qv(pu_dat, 0), 'h15);
    chk("sw_src",    qv(pu_src, 0), 2);
    chk("sw_lat",    qv(pu_cyc, 0) - qv(rd_cyc, 0), 2);
    chk("sw_idle",   int'(idle), 1);

    // Burst of three words from FIFO0.
    clear_logs();
    load(0, 6'h01); load(0, 6'h02); load(0, 6'h03);
    tick(10);
    chk("bu_nreads", rd_idx.size(), 3);
    chk("bu_rd_span", qv(rd_cyc, 2) - qv(rd_cyc, 0), 2);
    chk("bu_npush",  pu_dat.size(), 3);
    chk("bu_pu_span", qv(pu_cyc, 2) - qv(pu_cyc, 0), 2);
    for (int k = 0; k < 3; k++) chk($sformatf("bu_data%0d", k), qv(pu_dat, k), k + 1);

    // Pause after two reads of a five-word FIFO1.
    clear_logs();
    lc = cyc;
    for (int k = 0; k < 5; k++) load(1, 6'(8'h21 + k));
    tick(2);
    down_pause = 1'b1;
    pc = cyc;
    tick(6);
    chk("pz_nreads", rd_idx.size(), 2);
    chk("pz_last_rd", qv(rd_cyc, 1), pc);
    chk("pz_npush",  pu_dat.size(), 2);
    down_pause = 1'b0;
    rc = cyc;
    tick(12);
    chk("pz_resume", qv(rd_cyc, 2) - rc, 1);
    chk("pz_nreads_all", rd_idx.size(), 5);
    chk("pz_npush_all",  pu_dat.size(), 5);
    for (int k = 0; k < 5; k++) chk($sformatf("pz_data%0d", k), qv(pu_dat, k), 'h21 + k);

    // Arbitration with two words in every source (from a fresh reset).
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      load(i, 6'(i*8));
      load(i, 6'(i*8 + 1));
      nth[i] = 0;
    end
    tick(16);
    chk("arb_nreads", rd_idx.size(), 8);
    chk("arb_npush",  pu_dat.size(), 8);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("arb_rd%0d", k),  qv(rd_idx, k), exp_ord[k]);
      chk($sformatf("arb_src%0d", k), qv(pu_src, k), exp_ord[k]);
      ew = exp_ord[k]*8 + nth[exp_ord[k]];
      nth[exp_ord[k]]++;
      chk($sformatf("arb_dat%0d", k), qv(pu_dat, k), ew);
    end

    // Reset while two words are in flight.
    clear_logs();
    lc = cyc;
    load(3, 6'h31);
    load(3, 6'h32);
    tick(2);
    reset = 1'b1;
    tick(1);
    chk("mr_push0", int'(push), 0);
    chk("mr_read0", int'(fifo_read), 0);
    tick(1);
    chk("mr_push1", int'(push), 0);
    chk("mr_read1", int'(fifo_read), 0);
    chk("mr_idle",  int'(idle), 1);
    reset = 1'b0;
    tick(6);
    chk("mr_nreads", rd_idx.size(), 2);
    chk("mr_npush",  pu_dat.size(), 0);
    chk("mr_idle_end", int'(idle), 1);

    chk("protocol_viol", viol, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
